// File: rtl/bv_pkg.sv
// bv_pkg -- shared CCNET constants for the bill-validator transmit path.
// Holds the frame sync byte, command codes, frame lengths, the CRC16
// (Kermit) polynomial/initial value, pending-bit positions and the
// scheduler FSM state type.
`timescale 1ns/1ps
package bv_pkg;

  localparam logic [7:0] BV_SYNC       = 8'h02;

  localparam logic [7:0] BV_CMD_ACK    = 8'h00;
  localparam logic [7:0] BV_CMD_RESET  = 8'h30;
  localparam logic [7:0] BV_CMD_POLL   = 8'h33;
  localparam logic [7:0] BV_CMD_ENABLE = 8'h34;

  // Total frame byte count, CRC included.
  localparam logic [3:0] BV_LEN_SHORT  = 4'd6;
  localparam logic [3:0] BV_LEN_ENABLE = 4'd12;

  localparam logic [15:0] BV_CRC_POLY  = 16'h8408;
  localparam logic [15:0] BV_CRC_INIT  = 16'h0000;

  // Bit positions inside the pending vector {ack, reset, enable, poll}.
  localparam int BV_PEND_ACK    = 3;
  localparam int BV_PEND_RESET  = 2;
  localparam int BV_PEND_ENABLE = 1;
  localparam int BV_PEND_POLL   = 0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEND,
    ST_WAIT_BUSY,
    ST_WAIT_IDLE,
    ST_DONE
  } bvState_t;

endpackage

// File: rtl/bv_crc16.sv
// bv_crc16 -- combinational byte-wise CRC16 update (CCNET / Kermit,
// reflected polynomial 16'h8408, LSB first).
// Ports:
//   crc_in   [15:0] in  : running CRC before this byte
//   data_in  [7:0]  in  : byte being folded in
//   crc_out  [15:0] out : running CRC after this byte
`timescale 1ns/1ps
module bv_crc16
  import bv_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data_in,
  output logic [15:0] crc_out
);

  logic [15:0] crcWork;

  // NOTE: crcWork is a combinational scratch variable updated eight times in
  // one pass; blocking '=' is required here so each step sees the previous one.
  always_comb begin
    crcWork = crc_in ^ {8'h00, data_in};
    for (int i = 0; i < 8; i++) begin
      crcWork = crcWork[0] ? ((crcWork >> 1) ^ BV_CRC_POLY) : (crcWork >> 1);
    end
    crc_out = crcWork;
  end

endmodule

// File: rtl/bv_tx_scheduler.sv
// bv_tx_scheduler -- arbitrates ACK / RESET / ENABLE BILL TYPES / POLL
// frame requests onto a single async_transmitter and serialises each CCNET
// frame (sync, addr, len, cmd, data, CRC16 low, CRC16 high).
// Ports:
//   CLK_10MHZ       in  : system clock
//   rst_n           in  : asynchronous active-low reset
//   ack_req/reset_req/enable_req/poll_req in : one-cycle request pulses
//   bill_enable[23:0], bill_escrow[23:0] in  : ENABLE frame masks, MSB byte first
//   rx_active       in  : validator reply in progress, holds off frame start
//   tx_busy         in  : TxD_busy from the transmitter
//   tx_start        out : TxD_start, one-cycle pulse
//   tx_data[7:0]    out : TxD_data, valid while tx_start is high
//   busy            out : frame in progress (LOAD .. DONE)
//   pending[3:0]    out : latched requests {ack, reset, enable, poll}
//   frame_done      out : one-cycle pulse after the last CRC byte
//   frame_cmd[7:0]  out : command of the last completed frame
// Build option: define BV_POLL_TIMER_EN to add a free-running POLL_PERIOD
// timer that raises a poll request on every wrap.
`timescale 1ns/1ps
module bv_tx_scheduler
  import bv_pkg::*;
#(
  parameter int unsigned POLL_PERIOD = 2_000_000,
  parameter logic [7:0]  BV_ADDR     = 8'h03
) (
  input  logic        CLK_10MHZ,
  input  logic        rst_n,
  input  logic        ack_req,
  input  logic        reset_req,
  input  logic        enable_req,
  input  logic        poll_req,
  input  logic [23:0] bill_enable,
  input  logic [23:0] bill_escrow,
  input  logic        rx_active,
  input  logic        tx_busy,
  output logic        tx_start,
  output logic [7:0]  tx_data,
  output logic        busy,
  output logic [3:0]  pending,
  output logic        frame_done,
  output logic [7:0]  frame_cmd
);

  bvState_t    state, nextState;
  logic [3:0]  pendingReg;
  logic [3:0]  byteIdx;
  logic [3:0]  frameLen;
  logic [15:0] crcReg, crcNext;
  logic [7:0]  cmdReg;
  logic [47:0] maskReg;
  logic        waitCnt;
  logic [7:0]  frameCmdReg;
  logic        timerHit;

  logic [3:0]  selMask;
  logic [7:0]  selCmd;
  logic [3:0]  selLen;
  logic [7:0]  curByte;
  logic        isCrcLo, isCrcHi;
  logic        sendNow;

`ifdef BV_POLL_TIMER_EN
  logic [31:0] pollTimer;

  assign timerHit = (pollTimer == 32'(POLL_PERIOD - 1));

  always_ff @(posedge CLK_10MHZ or negedge rst_n) begin
    if (!rst_n)        pollTimer <= '0;
    else if (timerHit) pollTimer <= '0;
    else               pollTimer <= pollTimer + 32'd1;
  end
`else
  assign timerHit = 1'b0;
`endif

  // Fixed-priority pick among pending requests: ack > reset > enable > poll.
  always_comb begin
    selMask = 4'b0000;
    selCmd  = BV_CMD_POLL;
    selLen  = BV_LEN_SHORT;
    if (pendingReg[BV_PEND_ACK]) begin
      selMask = 4'b1000;
      selCmd  = BV_CMD_ACK;
    end else if (pendingReg[BV_PEND_RESET]) begin
      selMask = 4'b0100;
      selCmd  = BV_CMD_RESET;
    end else if (pendingReg[BV_PEND_ENABLE]) begin
      selMask = 4'b0010;
      selCmd  = BV_CMD_ENABLE;
      selLen  = BV_LEN_ENABLE;
    end else if (pendingReg[BV_PEND_POLL]) begin
      selMask = 4'b0001;
    end
  end

  // Byte at the current index; the last two positions carry the CRC.
  assign isCrcLo = (byteIdx == frameLen - 4'd2);
  assign isCrcHi = (byteIdx == frameLen - 4'd1);

  // NOTE: every output of a combinational block gets a default before the
  // case statement so no path leaves it unassigned and infers a latch.
  always_comb begin
    curByte = 8'h00;
    case (byteIdx)
      4'd0:    curByte = BV_SYNC;
      4'd1:    curByte = BV_ADDR;
      4'd2:    curByte = {4'h0, frameLen};
      4'd3:    curByte = cmdReg;
      4'd4:    curByte = maskReg[47:40];
      4'd5:    curByte = maskReg[39:32];
      4'd6:    curByte = maskReg[31:24];
      4'd7:    curByte = maskReg[23:16];
      4'd8:    curByte = maskReg[15:8];
      4'd9:    curByte = maskReg[7:0];
      default: curByte = 8'h00;
    endcase
    if (isCrcLo)      curByte = crcReg[7:0];
    else if (isCrcHi) curByte = crcReg[15:8];
  end

  bv_crc16 u_crc (
    .crc_in  (crcReg),
    .data_in (curByte),
    .crc_out (crcNext)
  );

  // Next-state logic.
  always_comb begin
    nextState = state;
    sendNow   = 1'b0;
    case (state)
      ST_IDLE:      if (|pendingReg && !rx_active) nextState = ST_LOAD;
      ST_LOAD:      nextState = ST_SEND;
      ST_SEND: begin
        if (!tx_busy) begin
          sendNow   = 1'b1;
          nextState = ST_WAIT_BUSY;
        end
      end
      // Proceed after two cycles even if the transmitter never shows busy.
      ST_WAIT_BUSY: if (tx_busy || waitCnt) nextState = ST_WAIT_IDLE;
      ST_WAIT_IDLE: begin
        if (!tx_busy) nextState = (byteIdx + 4'd1 < frameLen) ? ST_SEND : ST_DONE;
      end
      ST_DONE:      nextState = ST_IDLE;
      default:      nextState = ST_IDLE;
    endcase
  end

  // NOTE: all registered state uses non-blocking '<=' so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK_10MHZ or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= nextState;
  end

  always_ff @(posedge CLK_10MHZ or negedge rst_n) begin
    if (!rst_n) begin
      pendingReg  <= '0;
      byteIdx     <= '0;
      frameLen    <= '0;
      crcReg      <= BV_CRC_INIT;
      cmdReg      <= '0;
      maskReg     <= '0;
      waitCnt     <= 1'b0;
      frameCmdReg <= '0;
    end else begin
      // A new request in the same cycle as the LOAD clear keeps its bit set.
      pendingReg <= (pendingReg & ~((state == ST_LOAD) ? selMask : 4'b0000))
                  | {ack_req, reset_req, enable_req, poll_req | timerHit};

      if (state == ST_LOAD) begin
        byteIdx  <= '0;
        crcReg   <= BV_CRC_INIT;
        frameLen <= selLen;
        cmdReg   <= selCmd;
        maskReg  <= {bill_enable, bill_escrow};
      end

      if (sendNow) begin
        waitCnt <= 1'b0;
        if (!isCrcLo && !isCrcHi) crcReg <= crcNext;
      end

      if (state == ST_WAIT_BUSY) waitCnt <= 1'b1;

      if (state == ST_WAIT_IDLE && !tx_busy) byteIdx <= byteIdx + 4'd1;

      if (state == ST_DONE) frameCmdReg <= cmdReg;
    end
  end

  assign tx_start   = sendNow;
  assign tx_data    = sendNow ? curByte : 8'h00;
  assign busy       = (state != ST_IDLE);
  assign pending    = pendingReg;
  assign frame_done = (state == ST_DONE);
  assign frame_cmd  = frameCmdReg;

endmodule

// File: tb/tb_bv_tx_scheduler.sv
// tb_bv_tx_scheduler -- scoreboard bench for bv_tx_scheduler.
// Stimulus pushes expected frame bytes / commands into queues; a monitor
// pops and compares whenever tx_start or frame_done is seen. A simple
// transmitter model answers tx_start with a configurable busy window.
`timescale 1ns/1ps
module tb_bv_tx_scheduler;

  logic        CLK_10MHZ = 1'b0;
  logic        rst_n;
  logic        ack_req, reset_req, enable_req, poll_req;
  logic [23:0] bill_enable, bill_escrow;
  logic        rx_active;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        busy;
  logic [3:0]  pending;
  logic        frame_done;
  logic [7:0]  frame_cmd;

  always #50 CLK_10MHZ = ~CLK_10MHZ;

  bv_tx_scheduler #(.POLL_PERIOD(2_000_000), .BV_ADDR(8'h03)) dut (
    .CLK_10MHZ  (CLK_10MHZ),
    .rst_n      (rst_n),
    .ack_req    (ack_req),
    .reset_req  (reset_req),
    .enable_req (enable_req),
    .poll_req   (poll_req),
    .bill_enable(bill_enable),
    .bill_escrow(bill_escrow),
    .rx_active  (rx_active),
    .tx_busy    (tx_busy),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .busy       (busy),
    .pending    (pending),
    .frame_done (frame_done),
    .frame_cmd  (frame_cmd)
  );

  // Transmitter model: busy for busyLen cycles after each start (0 = never busy).
  logic [2:0] busyCnt = 3'd0;
  logic [2:0] busyLen = 3'd2;
  always @(posedge CLK_10MHZ) begin
    if (tx_start && busyLen != 3'd0) busyCnt <= busyLen;
    else if (busyCnt != 3'd0)        busyCnt <= busyCnt - 3'd1;
  end
  assign tx_busy = (busyCnt != 3'd0);

  int compared   = 0;
  int mismatched = 0;
  int startCount = 0;
  int doneCount  = 0;
  logic [7:0] expQ[$];
  logic [7:0] cmdQ[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference CRC: CCNET/Kermit, bit-serial, reflected.
  function automatic logic [15:0] crc_model(input logic [7:0] b[$]);
    logic [15:0] c = 16'h0000;
    foreach (b[i]) begin
      c ^= {8'h00, b[i]};
      repeat (8) c = c[0] ? ((c >> 1) ^ 16'h8408) : (c >> 1);
    end
    return c;
  endfunction

  task automatic push_frame(input logic [7:0] cmd, input logic [23:0] en, input logic [23:0] es);
    logic [7:0]  f[$];
    logic [15:0] c;
    f.push_back(8'h02);
    f.push_back(8'h03);
    f.push_back((cmd == 8'h34) ? 8'h0C : 8'h06);
    f.push_back(cmd);
    if (cmd == 8'h34) begin
      f.push_back(en[23:16]); f.push_back(en[15:8]); f.push_back(en[7:0]);
      f.push_back(es[23:16]); f.push_back(es[15:8]); f.push_back(es[7:0]);
    end
    c = crc_model(f);
    f.push_back(c[7:0]);
    f.push_back(c[15:8]);
    foreach (f[i]) expQ.push_back(f[i]);
    cmdQ.push_back(cmd);
  endtask

  task automatic push_literal(input logic [7:0] b[6], input logic [7:0] cmd);
    foreach (b[i]) expQ.push_back(b[i]);
    cmdQ.push_back(cmd);
  endtask

  task automatic pulse(input logic [3:0] m);
    @(posedge CLK_10MHZ); #1;
    {ack_req, reset_req, enable_req, poll_req} = m;
    @(posedge CLK_10MHZ); #1;
    {ack_req, reset_req, enable_req, poll_req} = 4'b0000;
  endtask

  task automatic wait_done(input int target);
    int n = 0;
    while (doneCount < target && n < 20000) begin
      @(negedge CLK_10MHZ);
      n++;
    end
    check("frames_completed", 32'(doneCount), 32'(target));
    repeat (3) @(posedge CLK_10MHZ);
  endtask

  // Monitor / scoreboard.
  logic       prevStart = 1'b0;
  bit         cmdCheck  = 1'b0;
  logic [7:0] cmdExp    = 8'h00;
  initial begin
    forever begin
      @(negedge CLK_10MHZ);
      if (cmdCheck) begin
        check("frame_cmd", 32'(frame_cmd), 32'(cmdExp));
        cmdCheck = 1'b0;
      end
      if (tx_start) begin
        startCount++;
        check("start_back_to_back", 32'(prevStart), 32'h0);
        check("start_while_busy", 32'(tx_busy), 32'h0);
        if (expQ.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL unexpected_tx_start: got data %0h expected no start at %0t", tx_data, $time);
        end else begin
          check("tx_data", 32'(tx_data), 32'(expQ.pop_front()));
        end
      end
      prevStart = tx_start;
      if (frame_done) begin
        doneCount++;
        if (cmdQ.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL unexpected_frame_done: got pulse expected none at %0t", $time);
        end else begin
          cmdExp   = cmdQ.pop_front();
          cmdCheck = 1'b1;
        end
      end
    end
  end

  initial begin
    int s0;
    int n;
    logic [3:0] m;
    logic [23:0] en, es;

    rst_n = 1'b0;
    {ack_req, reset_req, enable_req, poll_req} = 4'b0000;
    bill_enable = 24'h0; bill_escrow = 24'h0;
    rx_active = 1'b0;

    // Reset values.
    repeat (3) @(posedge CLK_10MHZ); #1;
    check("rst_tx_start",   32'(tx_start),   32'h0);
    check("rst_tx_data",    32'(tx_data),    32'h0);
    check("rst_busy",       32'(busy),       32'h0);
    check("rst_pending",    32'(pending),    32'h0);
    check("rst_frame_done", 32'(frame_done), 32'h0);
    check("rst_frame_cmd",  32'(frame_cmd),  32'h0);
    @(posedge CLK_10MHZ); #1 rst_n = 1'b1;
    repeat (2) @(posedge CLK_10MHZ);

    // POLL frame and request-to-start latency.
    push_literal('{8'h02, 8'h03, 8'h06, 8'h33, 8'hDA, 8'h81}, 8'h33);
    pulse(4'b0001);
    @(posedge CLK_10MHZ); @(posedge CLK_10MHZ); @(negedge CLK_10MHZ);
    check("req_to_start_latency", 32'(tx_start), 32'h1);
    wait_done(1);

    // ACK and POLL together: ACK first, POLL still pending meanwhile.
    push_literal('{8'h02, 8'h03, 8'h06, 8'h00, 8'hC2, 8'h82}, 8'h00);
    push_literal('{8'h02, 8'h03, 8'h06, 8'h33, 8'hDA, 8'h81}, 8'h33);
    s0 = startCount;
    pulse(4'b1001);
    n = 0;
    while (startCount == s0 && n < 100) begin @(negedge CLK_10MHZ); n++; end
    check("pending_during_ack", 32'(pending), 32'h1);
    wait_done(3);

    // RESET frame.
    push_literal('{8'h02, 8'h03, 8'h06, 8'h30, 8'h41, 8'hB3}, 8'h30);
    pulse(4'b0100);
    wait_done(4);

    // ENABLE frame; masks changed right after LOAD must not leak in.
    bill_enable = 24'hFFFFFF; bill_escrow = 24'h000000;
    push_frame(8'h34, 24'hFFFFFF, 24'h000000);
    pulse(4'b0010);
    n = 0;
    while (!busy && n < 100) begin @(negedge CLK_10MHZ); n++; end
    @(posedge CLK_10MHZ); #1;
    bill_enable = 24'h123456; bill_escrow = 24'hABCDEF;
    wait_done(5);

    // Request in the same cycle as its LOAD clear: frame is sent twice.
    push_literal('{8'h02, 8'h03, 8'h06, 8'h33, 8'hDA, 8'h81}, 8'h33);
    push_literal('{8'h02, 8'h03, 8'h06, 8'h33, 8'hDA, 8'h81}, 8'h33);
    @(posedge CLK_10MHZ); #1 poll_req = 1'b1;
    @(posedge CLK_10MHZ); #1 poll_req = 1'b0;
    @(posedge CLK_10MHZ); #1 poll_req = 1'b1;
    @(posedge CLK_10MHZ); #1 poll_req = 1'b0;
    check("set_wins_pending", 32'(pending), 32'h1);
    wait_done(7);

    // rx_active holds off the frame; repeated requests merge into one.
    push_literal('{8'h02, 8'h03, 8'h06, 8'h33, 8'hDA, 8'h81}, 8'h33);
    s0 = startCount;
    @(posedge CLK_10MHZ); #1 rx_active = 1'b1;
    pulse(4'b0001);
    pulse(4'b0001);
    repeat (500) @(posedge CLK_10MHZ);
    check("held_by_rx_active", 32'(startCount), 32'(s0));
    check("pending_while_held", 32'(pending), 32'h1);
    #1 rx_active = 1'b0;
    @(posedge CLK_10MHZ); @(posedge CLK_10MHZ); @(negedge CLK_10MHZ);
    check("start_after_rx_release", 32'(tx_start), 32'h1);
    wait_done(8);

    // Random request sets, masks and transmitter busy lengths.
    for (int it = 0; it < 25; it++) begin
      busyLen = 3'($urandom_range(0, 4));
      m  = 4'($urandom_range(1, 15));
      en = 24'($urandom);
      es = 24'($urandom);
      bill_enable = en; bill_escrow = es;
      if (m[3]) push_frame(8'h00, en, es);
      if (m[2]) push_frame(8'h30, en, es);
      if (m[1]) push_frame(8'h34, en, es);
      if (m[0]) push_frame(8'h33, en, es);
      n = doneCount + $countones(m);
      pulse(m);
      wait_done(n);
    end

    // Reset after the third byte aborts the frame.
    busyLen = 3'd2;
    expQ.push_back(8'h02); expQ.push_back(8'h03); expQ.push_back(8'h06);
    s0 = startCount;
    pulse(4'b0001);
    n = 0;
    while (startCount < s0 + 3 && n < 200) begin @(negedge CLK_10MHZ); n++; end
    @(posedge CLK_10MHZ); #1 rst_n = 1'b0;
    #1;
    check("abort_tx_start",   32'(tx_start),   32'h0);
    check("abort_tx_data",    32'(tx_data),    32'h0);
    check("abort_busy",       32'(busy),       32'h0);
    check("abort_pending",    32'(pending),    32'h0);
    check("abort_frame_done", 32'(frame_done), 32'h0);
    check("abort_frame_cmd",  32'(frame_cmd),  32'h0);
    repeat (3) @(posedge CLK_10MHZ); #1 rst_n = 1'b1;
    repeat (200) @(posedge CLK_10MHZ);
    check("no_start_after_abort", 32'(startCount), 32'(s0 + 3));
    check("pending_after_abort", 32'(pending), 32'h0);

    check("bytes_left_in_queue", 32'(expQ.size()), 32'h0);
    check("frames_left_in_queue", 32'(cmdQ.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
